// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: WB/LU request and register-file write bus of rf_write_arbiter.
// pend_mask exists only when RF_SCOREBOARD_EN is defined.
interface rf_write_arbiter_if #(
  parameter int ADDR_SIZE = 5,
  parameter int WORD      = 32,
  parameter int DEPTH     = 4
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic                 wb_valid;
  logic [ADDR_SIZE-1:0] wb_addr;
  logic [WORD-1:0]      wb_data;
  logic                 lu_valid;
  logic                 lu_ready;
  logic [ADDR_SIZE-1:0] lu_addr;
  logic [WORD-1:0]      lu_data;
  logic                 wb_stall;
  logic                 rf_regwrite;
  logic [ADDR_SIZE-1:0] rf_write_addr;
  logic [WORD-1:0]      rf_write_data;
  logic [CW-1:0]        fifo_count;
  logic                 err_overrun;
`ifdef RF_SCOREBOARD_EN
  logic [2**ADDR_SIZE-1:0] pend_mask;
  modport master (output wb_valid, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
                  input lu_ready, wb_stall, rf_regwrite, rf_write_addr, rf_write_data,
                  fifo_count, err_overrun, pend_mask);
  modport slave  (input wb_valid, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
                  output lu_ready, wb_stall, rf_regwrite, rf_write_addr, rf_write_data,
                  fifo_count, err_overrun, pend_mask);
`else
  modport master (output wb_valid, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
                  input lu_ready, wb_stall, rf_regwrite, rf_write_addr, rf_write_data,
                  fifo_count, err_overrun);
  modport slave  (input wb_valid, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
                  output lu_ready, wb_stall, rf_regwrite, rf_write_addr, rf_write_data,
                  fifo_count, err_overrun);
`endif
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the RF write port between WB (priority) and a FIFO-buffered LU
// with a starvation guard; RF_SCOREBOARD_EN adds per-register pending tracking (pend_mask).
module rf_write_arbiter #(
  parameter int ADDR_SIZE    = 5,
  parameter int WORD         = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input logic clk,
  input logic reset,
  rf_write_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [ADDR_SIZE-1:0] addr_mem [DEPTH];
  logic [WORD-1:0]      data_mem [DEPTH];
  logic [PW-1:0]        rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [SW-1:0]        starve_q, starve_d;
  logic                 we_q, we_d, err_q, err_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d, head_addr;
  logic [WORD-1:0]      data_q, data_d;
  logic                 wb_req, non_empty, stall, ready, push, pop;
  assign head_addr = addr_mem[rd_q];
  always_comb begin
    wb_req    = bus.wb_valid && bus.wb_addr != '0;
    non_empty = count_q != '0;
    stall     = starve_q == SW'(STARVE_LIMIT);
    ready     = count_q != CW'(DEPTH);
    pop       = non_empty && (stall || !wb_req);
    push      = bus.lu_valid && ready && bus.lu_addr != '0;
    rd_d      = pop ? rd_q + PW'(1) : rd_q;
    wr_d      = push ? wr_q + PW'(1) : wr_q;
    count_d   = count_q + CW'(push) - CW'(pop);
    // a non-empty FIFO that is not popped has necessarily lost to WB
    starve_d  = (!non_empty || pop) ? '0 : stall ? starve_q : starve_q + SW'(1);
    we_d      = pop || wb_req;
    addr_d    = pop ? head_addr : wb_req ? bus.wb_addr : addr_q;
    data_d    = pop ? data_mem[rd_q] : wb_req ? bus.wb_data : data_q;
    err_d     = err_q || (stall && non_empty && wb_req);
  end
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_q] <= bus.lu_addr;
      data_mem[wr_q] <= bus.lu_data;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q     <= '0;
      wr_q     <= '0;
      count_q  <= '0;
      starve_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end
  assign bus.lu_ready      = ready;
  assign bus.wb_stall      = stall;
  assign bus.rf_regwrite   = we_q;
  assign bus.rf_write_addr = addr_q;
  assign bus.rf_write_data = data_q;
  assign bus.fifo_count    = count_q;
  assign bus.err_overrun   = err_q;
`ifdef RF_SCOREBOARD_EN
  for (genvar g = 0; g < 2**ADDR_SIZE; g++) begin : g_pend
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else cnt_q <= cnt_q + CW'(push && bus.lu_addr == ADDR_SIZE'(g)) - CW'(pop && head_addr == ADDR_SIZE'(g));
    end
    assign bus.pend_mask[g] = (g != 0) && cnt_q != '0;
  end
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: randomized and directed stimulus checked against a queue-based reference model.
module tb_rf_write_arbiter;
  localparam int A = 5, W = 32, D = 4, L = 3;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  rf_write_arbiter_if #(.ADDR_SIZE(A), .WORD(W), .DEPTH(D)) bus();
  rf_write_arbiter #(.ADDR_SIZE(A), .WORD(W), .DEPTH(D), .STARVE_LIMIT(L)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  typedef struct { logic [A-1:0] a; logic [W-1:0] d; } ent_t;
  ent_t q[$];
  int checks = 0, errors = 0, starve = 0;
  logic e_we, e_err;
  logic [A-1:0] e_addr;
  logic [W-1:0] e_data;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    starve = 0; e_we = 0; e_err = 0; e_addr = '0; e_data = '0;
  endtask
  task automatic drive(logic wv, logic [A-1:0] wa, logic [W-1:0] wd, logic lv, logic [A-1:0] la, logic [W-1:0] ld);
    bus.wb_valid = wv; bus.wb_addr = wa; bus.wb_data = wd;
    bus.lu_valid = lv; bus.lu_addr = la; bus.lu_data = ld;
  endtask
  // one clock cycle: check pre-edge status, advance the model, check registered outputs
  task automatic cycle();
    bit ready, stall, nonempty, wreq, gf, push;
    logic [2**A-1:0] mask;
    ready = q.size() != D;
    stall = starve == L;
    nonempty = q.size() != 0;
    chk("lu_ready", 64'(bus.lu_ready), 64'(ready));
    chk("wb_stall", 64'(bus.wb_stall), 64'(stall));
    wreq = bus.wb_valid && bus.wb_addr != '0;
    gf = nonempty && (stall || !wreq);
    e_we = gf || wreq;
    if (gf) begin e_addr = q[0].a; e_data = q[0].d; end
    else if (wreq) begin e_addr = bus.wb_addr; e_data = bus.wb_data; end
    if (stall && nonempty && wreq) e_err = 1;
    if (!nonempty || gf) starve = 0;
    else if (starve < L) starve++;
    push = bus.lu_valid && ready && bus.lu_addr != '0;
    if (gf) void'(q.pop_front());
    if (push) q.push_back('{a: bus.lu_addr, d: bus.lu_data});
    @(posedge clk); #1;
    chk("rf_regwrite", 64'(bus.rf_regwrite), 64'(e_we));
    chk("rf_write_addr", 64'(bus.rf_write_addr), 64'(e_addr));
    chk("rf_write_data", 64'(bus.rf_write_data), 64'(e_data));
    chk("fifo_count", 64'(bus.fifo_count), 64'(q.size()));
    chk("err_overrun", 64'(bus.err_overrun), 64'(e_err));
    mask = '0;
    foreach (q[i]) mask[q[i].a] = 1'b1;
    mask[0] = 1'b0;
`ifdef RF_SCOREBOARD_EN
    chk("pend_mask", 64'(bus.pend_mask), 64'(mask));
`endif
  endtask
  initial begin
    int idx;
    bit saw_full;
    drive(0, '0, '0, 0, '0, '0);
    model_reset();
    #12;
    chk("rst_count", 64'(bus.fifo_count), 64'(0));
    chk("rst_we", 64'(bus.rf_regwrite), 64'(0));
    chk("rst_addr", 64'(bus.rf_write_addr), 64'(0));
    chk("rst_data", 64'(bus.rf_write_data), 64'(0));
    chk("rst_err", 64'(bus.err_overrun), 64'(0));
    chk("rst_stall", 64'(bus.wb_stall), 64'(0));
    chk("rst_ready", 64'(bus.lu_ready), 64'(1));
    @(negedge clk) reset = 1'b0;
    drive(1, 5, 32'hDEADBEEF, 0, '0, '0); cycle();
    chk("wb_only_addr", 64'(bus.rf_write_addr), 64'(5));
    chk("wb_only_data", 64'(bus.rf_write_data), 64'hDEADBEEF);
    drive(0, '0, '0, 0, '0, '0); cycle();
    drive(0, '0, '0, 1, 7, 32'h11); cycle();
    chk("lu_count1", 64'(bus.fifo_count), 64'(1));
    drive(0, '0, '0, 0, '0, '0); cycle();
    chk("lu_drain_addr", 64'(bus.rf_write_addr), 64'(7));
    chk("lu_drain_data", 64'(bus.rf_write_data), 64'h11);
    chk("lu_drain_count", 64'(bus.fifo_count), 64'(0));
    idx = 0; saw_full = 0;
    for (int i = 0; i < 8; i++) begin
      drive(!bus.wb_stall, 3, $urandom, idx < 5, 5'(10 + idx), 32'hA0 + 32'(idx));
      if (!bus.lu_ready) saw_full = 1;
      if (idx < 5 && bus.lu_ready) idx++;
      cycle();
    end
    chk("full_seen", 64'(saw_full), 64'(1));
    chk("full_all_pushed", 64'(idx), 64'(5));
    drive(0, '0, '0, 0, '0, '0);
    repeat (6) cycle();
    drive(1, 4, 32'h1, 1, 12, 32'h55); cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1, 4, 32'h100 + 32'(i), 0, '0, '0);
      if (i == 3) chk("stall_4th", 64'(bus.wb_stall), 64'(1));
      cycle();
    end
    chk("stall_head_addr", 64'(bus.rf_write_addr), 64'(12));
    chk("overrun_set", 64'(bus.err_overrun), 64'(1));
    drive(0, '0, '0, 0, '0, '0); cycle();
    drive(1, 0, 32'h77, 1, 0, 32'h88); cycle();
    chk("r0_no_write", 64'(bus.rf_regwrite), 64'(0));
    chk("r0_count", 64'(bus.fifo_count), 64'(0));
    for (int i = 0; i < 3; i++) begin
      drive(1, 6, $urandom, 1, 5'(20 + i), $urandom); cycle();
    end
    chk("pre_rst_count", 64'(bus.fifo_count), 64'(3));
    reset = 1'b1;
    model_reset();
    drive(0, '0, '0, 0, '0, '0);
    #1;
    chk("mid_rst_count", 64'(bus.fifo_count), 64'(0));
    chk("mid_rst_we", 64'(bus.rf_regwrite), 64'(0));
    chk("mid_rst_ready", 64'(bus.lu_ready), 64'(1));
    chk("mid_rst_err", 64'(bus.err_overrun), 64'(0));
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (3) cycle();
    drive(1, 3, $urandom, 1, 9, 32'h901); cycle();
    drive(1, 3, $urandom, 1, 9, 32'h902); cycle();
    drive(0, '0, '0, 0, '0, '0); cycle();
`ifdef RF_SCOREBOARD_EN
    chk("pend9_after_pop1", 64'(bus.pend_mask[9]), 64'(1));
`endif
    cycle();
`ifdef RF_SCOREBOARD_EN
    chk("pend9_after_pop2", 64'(bus.pend_mask[9]), 64'(0));
`endif
    chk("dup_last_data", 64'(bus.rf_write_data), 64'h902);
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 6 && (!bus.wb_stall || $urandom_range(0, 19) == 0),
            5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between two requesters: the pipeline writeback stage (WB) and a long-latency unit (LU), e.g. mult/div or a late load return.
- WB has fixed priority and no backpressure.
- LU results are buffered in a DEPTH-entry FIFO and drain into idle write cycles. A starvation guard forces a drain slot when needed.
- Outputs are registered on posedge, so they are stable when the register file commits on negedge.

Parameters:
- ADDR_SIZE, 5, register address width.
- WORD, 32, data width.
- DEPTH, 4, LU FIFO entries; power of 2, at least 2.
- STARVE_LIMIT, 3, consecutive cycles a non-empty FIFO may lose to WB before wb_stall is raised; at least 1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high.
- wb_valid  input  1  WB write request.
- wb_addr  input  ADDR_SIZE  WB destination register.
- wb_data  input  WORD  WB write data.
- lu_valid  input  1  LU result valid.
- lu_ready  output  1  FIFO can accept an LU result.
- lu_addr  input  ADDR_SIZE  LU destination register.
- lu_data  input  WORD  LU result data.
- wb_stall  output  1  pipeline must hold wb_valid low this cycle.
- rf_regwrite  output  1  register-file write enable.
- rf_write_addr  output  ADDR_SIZE  register-file write address.
- rf_write_data  output  WORD  register-file write data.
- fifo_count  output  log2(DEPTH)+1  current FIFO occupancy.
- err_overrun  output  1  sticky; WB request dropped during wb_stall.

Behaviour:
- Reset, asynchronous: FIFO empty; fifo_count=0, starve_cnt=0, rf_regwrite=0, rf_write_addr=0, rf_write_data=0, err_overrun=0, wb_stall=0, lu_ready=1. Reset asserted mid-operation discards all queued entries, and no write is issued in the reset cycle or the cycle after.
- WB request: wb_req = wb_valid && wb_addr!=0. Writes to r0 are never issued.
- LU push: occurs when lu_valid && lu_ready. If lu_addr==0 the handshake completes but nothing is enqueued.
- lu_ready = (fifo_count != DEPTH), decided from registered count only. A same-cycle pop does not raise ready when full.
- Grant, evaluated each cycle:
  - wb_stall=1 and FIFO non-empty: grant FIFO head. If wb_req is also 1, that WB write is dropped and err_overrun is set; it stays set until reset.
  - else if wb_req: grant WB.
  - else if FIFO non-empty: grant FIFO head (pop).
  - else no grant.
- Latency: a grant in cycle N drives rf_regwrite=1 with that addr/data from posedge N+1 through posedge N+2. The register file commits on the negedge inside cycle N+1. rf_regwrite=0 after a no-grant cycle; addr/data then hold their previous values.
- Pass-through: an LU push into an empty FIFO becomes grantable the next cycle. There is no same-cycle bypass, so minimum LU latency is 2 cycles.
- Simultaneous push and pop: fifo_count unchanged. Pointers wrap modulo DEPTH.
- Starvation counter:
  - starve_cnt increments, saturating at STARVE_LIMIT, each cycle the FIFO is non-empty and WB is granted.
  - It clears to 0 on any FIFO grant or when the FIFO is empty.
  - wb_stall = (starve_cnt == STARVE_LIMIT), a decode of registered state.
- Ordering: FIFO entries drain strictly in arrival order. Cross-port ordering of writes to the same register is the hazard unit's responsibility.

Optional Feature:
- Macro RF_SCOREBOARD_EN.
- Defined:
  - Adds output pend_mask (2**ADDR_SIZE bits). Bit k is set while at least one FIFO entry targets register k; bit 0 is always 0.
  - A per-register pending counter (log2(DEPTH)+1 bits) increments on enqueue and decrements on pop, so duplicate addresses are tracked correctly.
  - Simultaneous enqueue and pop of the same address leaves its count unchanged.
  - All counts clear on reset.
  - pend_mask is driven from the registered counts.
- Undefined: no pend_mask port and no counters; the rest of the behaviour is identical.

Test Plan:
- WB only: wb_valid=1, addr=5, data=0xDEADBEEF in cycle 1 → rf_regwrite=1, rf_write_addr=5, rf_write_data=0xDEADBEEF in cycle 2; FIFO stays empty.
- LU idle drain: push addr=7, data=0x11 with WB idle → fifo_count=1 next cycle; rf write of reg 7 = 0x11 one cycle later; fifo_count returns to 0.
- Full FIFO: DEPTH=4 pushes with WB busy every cycle → lu_ready=0 at fifo_count=4; a 5th lu_valid is held (not accepted) until a pop; no data loss; drain order matches push order.
- Starvation: FIFO holds 1 entry, WB requests every cycle with STARVE_LIMIT=3 → wb_stall=1 in the 4th cycle; FIFO head is written; starve_cnt=0 afterwards. If wb_valid is also held high during that stall cycle, err_overrun=1 and that WB write is absent.
- r0 and reset: WB and LU writes to addr 0 → no rf_regwrite, fifo_count unchanged. Assert reset with 3 queued entries → fifo_count=0, rf_regwrite=0, lu_ready=1, and no stale writes after release.
- RF_SCOREBOARD_EN: enqueue addr 9 twice then pop one → pend_mask[9]=1; after the second pop → pend_mask[9]=0.
